// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-to-UART drain.
// Provides the FSM state encoding, UART character/frame sizes and a small
// helper to derive the number of bytes carried by one FIFO word.
package uart_pkg;

    // Drain FSM states; FETCH is only visited when the FIFO has a read latency of 1
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam int unsigned BITS_PER_CHAR = 8;
    localparam int unsigned FRAME_BITS    = 10;

    // Number of UART characters needed to carry one word of the given width
    function automatic int unsigned bytes_per_word(input int unsigned width);
        return width / BITS_PER_CHAR;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// UART bit timer.
// Counts 0..clocksPerBit-1 while run is high and wraps at every bit boundary;
// held at zero while run is low so a new frame always starts with a full bit.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous, active-high
//   run    in   1 = a frame is on the line, count
//   tick   out  high on the last cycle of each bit period
module uart_bit_timer #(
    parameter int unsigned clocksPerBit = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(clocksPerBit);

    logic [CNT_W-1:0] count;

    assign tick = run & (count == CNT_W'(clocksPerBit - 1));

    // Free-running bit counter, parked at zero between frames
    always_ff @(posedge clock) begin
        if (reset || !run || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_drain.sv
// FIFO-to-UART drain.
// Pops bitWidth-bit words from a word FIFO and sends each as bitWidth/8
// 8N1 frames, least significant byte first, least significant bit first.
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high
//   enable     in   1 = may start new words; 0 = finish current word then idle
//   fifoEmpty  in   FIFO empty flag
//   fifoData   in   FIFO pop data (valid in the pop cycle or one cycle later)
//   fifoPop    out  one-cycle pop strobe per word
//   txd        out  UART serial output, idle high, registered
//   busy       out  high from the pop cycle until the last stop bit ends
//   wordDone   out  pulse on the last cycle of the final stop bit of a word
module fifo_uart_drain
    import uart_pkg::*;
#(
    parameter int unsigned bitWidth     = 32,
    parameter int unsigned clocksPerBit = 434,
    parameter int unsigned readLatency  = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                fifoEmpty,
    input  logic [bitWidth-1:0] fifoData,
    output logic                fifoPop,
    output logic                txd,
    output logic                busy,
    output logic                wordDone
);

    localparam int unsigned NUM_BYTES = bytes_per_word(bitWidth);
    localparam int unsigned BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned BIT_W     = $clog2(BITS_PER_CHAR);

    state_t              state;
    logic [bitWidth-1:0] shift;
    logic [BIT_W-1:0]    bitIdx;
    logic [BYTE_W-1:0]   byteIdx;
    logic                txdReg;
    logic                run;
    logic                tick;
    logic                lastByte;

    // Pop is decided in the idle cycle itself so back-to-back words lose no time
    assign fifoPop  = (state == IDLE) & enable & ~fifoEmpty & ~reset;
    assign run      = (state == START) | (state == DATA) | (state == STOP);
    assign lastByte = (byteIdx == BYTE_W'(NUM_BYTES - 1));
    assign wordDone = (state == STOP) & tick & lastByte;
    assign busy     = (state != IDLE) | fifoPop;
    assign txd      = txdReg;

    uart_bit_timer #(
        .clocksPerBit (clocksPerBit)
    ) bitTimer (
        .clock (clock),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    // Drain FSM; txd is loaded one bit ahead so it changes exactly on bit boundaries
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            txdReg  <= 1'b1;
            shift   <= '0;
            bitIdx  <= '0;
            byteIdx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txdReg <= 1'b1;
                    if (fifoPop) begin
                        bitIdx  <= '0;
                        byteIdx <= '0;
                        if (readLatency == 0) begin
                            shift  <= fifoData;
                            txdReg <= 1'b0;
                            state  <= START;
                        end else begin
                            state  <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    shift  <= fifoData;
                    txdReg <= 1'b0;
                    state  <= START;
                end

                START: begin
                    if (tick) begin
                        txdReg <= shift[0];
                        bitIdx <= '0;
                        state  <= DATA;
                    end
                end

                // Each data bit shifts the whole word, so after 8 bits the next byte sits at [7:0]
                DATA: begin
                    if (tick) begin
                        shift  <= shift >> 1;
                        bitIdx <= bitIdx + BIT_W'(1);
                        if (bitIdx == BIT_W'(BITS_PER_CHAR - 1)) begin
                            txdReg <= 1'b1;
                            state  <= STOP;
                        end else begin
                            txdReg <= shift[1];
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (lastByte) begin
                            state <= IDLE;
                        end else begin
                            byteIdx <= byteIdx + BYTE_W'(1);
                            txdReg  <= 1'b0;
                            state   <= START;
                        end
                    end
                end

                default: begin
                    txdReg <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
